irq_ctrl8: RTL and testbench
============================

IRQ_CTRL8 -- requirements
Module: irq_ctrl8

Interface
REQ-001 SHALL have the parameter list: none; all widths are fixed at 8 request lines and a 3-bit id.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port irq_in  input  8  raw request lines; bit 7 has the highest priority.
REQ-005 SHALL have port mask_we  input  1  load strobe for the mask register.
REQ-006 SHALL have port mask_data  input  8  new mask value; 1 = line disabled.
REQ-007 SHALL have port irq_ack  input  1  consumer accepts the presented request.
REQ-008 SHALL have port eoi  input  1  end-of-interrupt from the consumer.
REQ-009 SHALL have port irq_req  output  1  request valid to the consumer.
REQ-010 SHALL have port irq_id  output  3  id of the presented or in-service request.
REQ-011 SHALL have port in_service  output  1  high while an acknowledged request awaits eoi.
REQ-012 SHALL have port pending  output  8  pending register, unmasked view.
REQ-013 SHALL have port ack_cnt  output  8  count of acknowledged requests.

Function
REQ-014 SHALL register irq_in into irq_prev every cycle and detect a rising edge per bit as irq_in & ~irq_prev.
REQ-015 SHALL set pending[i] on the cycle after a rising edge is detected on bit i; level-held lines SHALL NOT re-trigger.
REQ-016 SHALL load the mask from mask_data on the edge where mask_we=1; masked bits SHALL stay pending but SHALL NOT be selected.
REQ-017 SHALL select the highest set bit of (pending & ~mask) by fixed priority, e.g. 8'b01000001 -> id 3'b110.
REQ-018 SHALL implement FSM states IDLE, REQ and SERVICE.
REQ-019 In IDLE, if (pending & ~mask) != 0, the FSM SHALL latch the selected id into irq_id, go to REQ and assert irq_req.
REQ-020 In REQ, irq_id and irq_req SHALL hold stable until irq_ack=1, even if the mask changes or a higher-priority line becomes pending.
REQ-021 On irq_ack in REQ, the FSM SHALL clear pending[irq_id], deassert irq_req, increment ack_cnt (wrapping 8'hFF -> 8'h00), go to SERVICE and assert in_service.
REQ-022 In SERVICE, new requests SHALL only accumulate in pending; on eoi=1 the FSM SHALL return to IDLE and deassert in_service.
REQ-023 irq_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-024 If a new edge on bit i and the clear of bit i occur in the same cycle, the set SHALL win.
REQ-025 Latency SHALL be: edge sampled at clock k -> pending set after edge k -> irq_req high after edge k+1 (FSM in IDLE).
REQ-026 Back-to-back operation SHALL be supported: eoi in SERVICE with work pending -> IDLE for one cycle -> REQ on the next edge.

Reset
REQ-027 rst SHALL asynchronously clear irq_prev, pending, mask and ack_cnt to 0, force the FSM to IDLE, and drive irq_req=0, irq_id=0 and in_service=0.
REQ-028 A line held high through reset SHALL register one edge on the first clock after rst falls.
REQ-029 rst asserted mid-REQ or mid-SERVICE SHALL discard all pending requests; no ack_cnt increment SHALL occur.

Structure
REQ-030 SHALL place the FSM state encoding and the IRQ_W=8 and ID_W=3 constants in a shared package (irq_pkg).
REQ-031 SHALL instantiate pr_encoder8_3 as the sole sub-module for fixed-priority selection of (pending & ~mask).

Verification
REQ-032 Reset check: pulse irq_in=8'h01 while rst=1, release rst -> pending=8'h01 one cycle later, then irq_req=1 with irq_id=0.
REQ-033 Priority check: simultaneous edges on irq_in=8'b01000001 -> irq_id=3'b110; after ack and eoi -> irq_id=3'b000 presented.
REQ-034 Mask check: mask=8'h80, edge on bit 7 -> irq_req stays 0 and pending=8'h80; write mask=8'h00 -> irq_req=1 with irq_id=7.
REQ-035 Hold check: edge on bit 3 presented (irq_id=3); edge on bit 5 arrives before ack -> irq_id stays 3 until ack; after eoi -> irq_id=5.
REQ-036 Set/clear race check: re-edge bit 2 in the same cycle as its ack -> pending[2]=1 after ack; ack_cnt wraps 8'hFF -> 8'h00 on the 256th ack.
REQ-037 Reset mid-operation check: assert rst in SERVICE -> in_service=0, pending=0 and ack_cnt=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared widths and FSM encoding for the 8-line interrupt controller
package irq_pkg;
    localparam int IRQ_W = 8;
    localparam int ID_W  = 3;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;
endpackage

// File: rtl/irq_ctrl8_if.sv
// irq_ctrl8_if: request lines, mask load and consumer handshake of irq_ctrl8
interface irq_ctrl8_if;
    import irq_pkg::*;
    logic [IRQ_W-1:0] irq_in;
    logic             mask_we;
    logic [IRQ_W-1:0] mask_data;
    logic             irq_ack;
    logic             eoi;
    logic             irq_req;
    logic [ID_W-1:0]  irq_id;
    logic             in_service;
    logic [IRQ_W-1:0] pending;
    logic [IRQ_W-1:0] ack_cnt;
    modport slave (
        input  irq_in, mask_we, mask_data, irq_ack, eoi,
        output irq_req, irq_id, in_service, pending, ack_cnt
    );
    modport master (
        output irq_in, mask_we, mask_data, irq_ack, eoi,
        input  irq_req, irq_id, in_service, pending, ack_cnt
    );
endinterface

// File: rtl/pr_encoder8_3.sv
// pr_encoder8_3: fixed-priority encoder, bit 7 wins
module pr_encoder8_3
    import irq_pkg::*;
(
    input  logic [IRQ_W-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);
    // ascending scan so the highest set bit overwrites lower ones
    always_comb begin
        id = '0;
        for (int i = 0; i < IRQ_W; i++)
            if (req[i]) id = ID_W'(i);
        valid = |req;
    end
endmodule

// File: rtl/irq_ctrl8.sv
// irq_ctrl8: edge-triggered 8-line interrupt controller with mask and ack/eoi handshake
module irq_ctrl8
    import irq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    irq_ctrl8_if.slave  bus
);
    logic [IRQ_W-1:0] irq_prev;
    logic [IRQ_W-1:0] mask;
    logic [IRQ_W-1:0] rise;
    logic [IRQ_W-1:0] clr;
    logic [ID_W-1:0]  sel_id;
    logic             sel_valid;
    logic             ack_fire;
    irq_state_t       state, next;

    assign rise     = bus.irq_in & ~irq_prev;
    assign ack_fire = (state == REQ) && bus.irq_ack;
    assign clr      = ack_fire ? ({{(IRQ_W-1){1'b0}}, 1'b1} << bus.irq_id) : '0;

    pr_encoder8_3 u_enc (
        .req   (bus.pending & ~mask),
        .id    (sel_id),
        .valid (sel_valid)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // next-state: present when work is eligible, wait for ack, then for eoi
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = sel_valid   ? REQ     : IDLE;
            REQ:     next = bus.irq_ack ? SERVICE : REQ;
            SERVICE: next = bus.eoi     ? IDLE    : SERVICE;
            default: next = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        bus.irq_req    = state == REQ;
        bus.in_service = state == SERVICE;
    end

    // edge history, mask, pending (set beats clear), latched id and ack counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev    <= '0;
            mask        <= '0;
            bus.pending <= '0;
            bus.irq_id  <= '0;
            bus.ack_cnt <= '0;
        end else begin
            irq_prev    <= bus.irq_in;
            mask        <= bus.mask_we ? bus.mask_data : mask;
            bus.pending <= (bus.pending & ~clr) | rise;
            bus.irq_id  <= (state == IDLE && sel_valid) ? sel_id : bus.irq_id;
            bus.ack_cnt <= bus.ack_cnt + {{(IRQ_W-1){1'b0}}, ack_fire};
        end
    end
endmodule

// File: tb/tb_irq_ctrl8.sv
// tb_irq_ctrl8: directed self-checking bench for irq_ctrl8
module tb_irq_ctrl8;
    logic clk;
    logic rst;
    int checks = 0;
    int errors = 0;

    irq_ctrl8_if bus();

    irq_ctrl8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.irq_in = '0; bus.mask_we = 0; bus.mask_data = '0; bus.irq_ack = 0; bus.eoi = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.irq_in = 8'h01; bus.mask_we = 0; bus.mask_data = '0; bus.irq_ack = 0; bus.eoi = 0;
        tick(); tick();
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL rst_irq_req got %b exp 0", bus.irq_req); end
        checks++; if (bus.irq_id !== 3'd0) begin errors++; $display("FAIL rst_irq_id got %0d exp 0", bus.irq_id); end
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL rst_in_service got %b exp 0", bus.in_service); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_pending got %h exp 00", bus.pending); end
        checks++; if (bus.ack_cnt !== 8'h00) begin errors++; $display("FAIL rst_ack_cnt got %h exp 00", bus.ack_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL rst_edge_pending got %h exp 01", bus.pending); end
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL rst_latency_req got %b exp 0", bus.irq_req); end
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd0) begin errors++; $display("FAIL rst_present got req=%b id=%0d exp req=1 id=0", bus.irq_req, bus.irq_id); end
        ack();
        checks++; if (bus.in_service !== 1'b1 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL rst_ack_state got svc=%b req=%b exp svc=1 req=0", bus.in_service, bus.irq_req); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL level_no_retrigger got %h exp 00", bus.pending); end
        checks++; if (bus.ack_cnt !== 8'h01) begin errors++; $display("FAIL rst_ack_cnt got %h exp 01", bus.ack_cnt); end
        eoi();
        checks++; if (bus.in_service !== 1'b0 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL rst_eoi got svc=%b req=%b exp 0 0", bus.in_service, bus.irq_req); end
        tick();
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL level_no_req got %b exp 0", bus.irq_req); end
        bus.irq_in = '0;
    endtask

    task automatic test_priority();
        do_reset();
        bus.irq_in = 8'b0100_0001;
        tick();
        checks++; if (bus.pending !== 8'h41) begin errors++; $display("FAIL prio_pending got %h exp 41", bus.pending); end
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd6) begin errors++; $display("FAIL prio_id got req=%b id=%0d exp req=1 id=6", bus.irq_req, bus.irq_id); end
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        checks++; if (bus.irq_req !== 1'b1 || bus.in_service !== 1'b0) begin errors++; $display("FAIL eoi_in_req_ignored got req=%b svc=%b exp 1 0", bus.irq_req, bus.in_service); end
        ack();
        checks++; if (bus.in_service !== 1'b1 || bus.irq_id !== 3'd6 || bus.pending !== 8'h01) begin errors++; $display("FAIL prio_service got svc=%b id=%0d pend=%h exp 1 6 01", bus.in_service, bus.irq_id, bus.pending); end
        ack();
        checks++; if (bus.ack_cnt !== 8'h01 || bus.pending !== 8'h01) begin errors++; $display("FAIL ack_in_service_ignored got cnt=%h pend=%h exp 01 01", bus.ack_cnt, bus.pending); end
        eoi();
        checks++; if (bus.irq_req !== 1'b0 || bus.in_service !== 1'b0) begin errors++; $display("FAIL b2b_idle got req=%b svc=%b exp 0 0", bus.irq_req, bus.in_service); end
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd0) begin errors++; $display("FAIL prio_second got req=%b id=%0d exp req=1 id=0", bus.irq_req, bus.irq_id); end
        ack();
        eoi();
        checks++; if (bus.ack_cnt !== 8'h02) begin errors++; $display("FAIL prio_ack_cnt got %h exp 02", bus.ack_cnt); end
        bus.irq_in = '0;
    endtask

    task automatic test_mask();
        do_reset();
        bus.mask_we = 1'b1; bus.mask_data = 8'h80;
        tick();
        bus.mask_we = 1'b0;
        bus.irq_in = 8'h80;
        tick(); tick(); tick();
        checks++; if (bus.irq_req !== 1'b0 || bus.pending !== 8'h80) begin errors++; $display("FAIL mask_block got req=%b pend=%h exp 0 80", bus.irq_req, bus.pending); end
        bus.mask_we = 1'b1; bus.mask_data = 8'h00;
        tick();
        bus.mask_we = 1'b0;
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL mask_latency got %b exp 0", bus.irq_req); end
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd7) begin errors++; $display("FAIL mask_release got req=%b id=%0d exp 1 7", bus.irq_req, bus.irq_id); end
        bus.mask_we = 1'b1; bus.mask_data = 8'hFF;
        tick();
        bus.mask_we = 1'b0;
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd7) begin errors++; $display("FAIL mask_hold got req=%b id=%0d exp 1 7", bus.irq_req, bus.irq_id); end
        ack();
        eoi();
        bus.irq_in = '0;
    endtask

    task automatic test_hold();
        do_reset();
        bus.irq_in = 8'h08;
        tick(); tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd3) begin errors++; $display("FAIL hold_first got req=%b id=%0d exp 1 3", bus.irq_req, bus.irq_id); end
        bus.irq_in = 8'h28;
        tick(); tick();
        checks++; if (bus.pending !== 8'h28 || bus.irq_id !== 3'd3 || bus.irq_req !== 1'b1) begin errors++; $display("FAIL hold_stable got pend=%h id=%0d req=%b exp 28 3 1", bus.pending, bus.irq_id, bus.irq_req); end
        ack();
        checks++; if (bus.in_service !== 1'b1 || bus.irq_id !== 3'd3 || bus.pending !== 8'h20) begin errors++; $display("FAIL hold_ack got svc=%b id=%0d pend=%h exp 1 3 20", bus.in_service, bus.irq_id, bus.pending); end
        eoi();
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd5) begin errors++; $display("FAIL hold_next got req=%b id=%0d exp 1 5", bus.irq_req, bus.irq_id); end
        ack();
        eoi();
        bus.irq_in = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.irq_in = 8'h04;
        tick(); tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd2) begin errors++; $display("FAIL race_present got req=%b id=%0d exp 1 2", bus.irq_req, bus.irq_id); end
        bus.irq_in = 8'h00;
        tick();
        bus.irq_in = 8'h04;
        ack();
        checks++; if (bus.pending !== 8'h04 || bus.in_service !== 1'b1 || bus.ack_cnt !== 8'h01) begin errors++; $display("FAIL race_set_wins got pend=%h svc=%b cnt=%h exp 04 1 01", bus.pending, bus.in_service, bus.ack_cnt); end
        eoi();
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd2) begin errors++; $display("FAIL race_reserve got req=%b id=%0d exp 1 2", bus.irq_req, bus.irq_id); end
        ack();
        eoi();
        bus.irq_in = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            bus.irq_in = 8'h01;
            tick();
            bus.irq_in = 8'h00;
            tick();
            ack();
            eoi();
            if (n == 255) begin
                checks++; if (bus.ack_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_ff got %h exp ff", bus.ack_cnt); end
            end
        end
        checks++; if (bus.ack_cnt !== 8'h00) begin errors++; $display("FAIL wrap_00 got %h exp 00", bus.ack_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.irq_in = 8'h30;
        tick(); tick();
        ack();
        checks++; if (bus.in_service !== 1'b1 || bus.pending !== 8'h10 || bus.ack_cnt !== 8'h01) begin errors++; $display("FAIL mid_pre got svc=%b pend=%h cnt=%h exp 1 10 01", bus.in_service, bus.pending, bus.ack_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.in_service !== 1'b0 || bus.pending !== 8'h00 || bus.ack_cnt !== 8'h00 || bus.irq_req !== 1'b0 || bus.irq_id !== 3'd0) begin errors++; $display("FAIL mid_async got svc=%b pend=%h cnt=%h req=%b id=%0d exp 0 00 00 0 0", bus.in_service, bus.pending, bus.ack_cnt, bus.irq_req, bus.irq_id); end
        bus.irq_in = 8'h00;
        tick();
        rst = 1'b0;
        bus.irq_in = 8'h02;
        tick(); tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd1) begin errors++; $display("FAIL mid_req_pre got req=%b id=%0d exp 1 1", bus.irq_req, bus.irq_id); end
        bus.irq_ack = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.irq_req !== 1'b0 || bus.pending !== 8'h00 || bus.ack_cnt !== 8'h00) begin errors++; $display("FAIL mid_req_async got req=%b pend=%h cnt=%h exp 0 00 00", bus.irq_req, bus.pending, bus.ack_cnt); end
        tick();
        checks++; if (bus.ack_cnt !== 8'h00 || bus.in_service !== 1'b0) begin errors++; $display("FAIL mid_req_no_ack got cnt=%h svc=%b exp 00 0", bus.ack_cnt, bus.in_service); end
        bus.irq_ack = 1'b0;
        bus.irq_in = 8'h00;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mask();
        test_hold();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
